lc2k_mem_stage: RTL and testbench
=================================

// Module: lc2k_mem_stage
// PURPOSE
//  LC2K pipeline memory stage. Sits between the execute stage and writeback.
//  Holds the EX/MEM instruction and runs a req/ack handshake to the data memory for lw/sw.
//  Stalls execute while an access is outstanding, then presents one registered MEM/WB result.
//  Detects out-of-range addresses and unacknowledged accesses, and freezes on halt or error.
// PARAMETERS
//  ADDR_W   6   data memory word-address width; valid addresses are 0..2**ADDR_W-1
//  TIMEOUT  16  maximum number of cycles in REQ without mem_ack before an error is raised
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  ex_valid       in   1       execute stage presents an instruction
//  ex_ready       out  1       stage accepts an instruction this cycle
//  ex_opcode      in   3       add=0 nor=1 lw=2 sw=3 beq=4 jalr=5 halt=6 noop=7
//  ex_alu_result  in   32      ALU result: memory address for lw/sw, link value (PC+1) for jalr
//  ex_regb_value  in   32      store data for sw
//  ex_dest_reg    in   3       destination register index
//  ex_reg_write   in   1       instruction writes the register file
//  mem_req        out  1       memory request; held high until mem_ack
//  mem_we         out  1       1 = write, 0 = read; valid while mem_req is high
//  mem_addr       out  ADDR_W  word address
//  mem_wdata      out  32      store data
//  mem_rdata      in   32      load data; valid in the mem_ack cycle
//  mem_ack        in   1       memory has completed the request
//  wb_valid       out  1       MEM/WB holds a result; high for exactly 1 cycle per instruction
//  wb_opcode      out  3       opcode of the retiring instruction
//  wb_data        out  32      register writeback value
//  wb_dest_reg    out  3       destination register index
//  wb_reg_write   out  1       write enable to the register file
//  halted         out  1       sticky: a halt instruction has retired
//  mem_error      out  1       sticky: bad address or timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (ex_ready=0 during reset); timeout counter cleared.
//    Reset takes effect from any state, including mid-REQ; an in-flight access is abandoned.
//  States: IDLE, REQ, HALT, ERR.
//    ex_ready = 1 only in IDLE.
//    An instruction is accepted when ex_valid & ex_ready.
//  IDLE, accept of a non-memory opcode (0,1,4,5,7):
//    next cycle wb_valid=1, wb_data=ex_alu_result, wb_reg_write=ex_reg_write.
//    Latency is 1 cycle and throughput is 1 per cycle.
//  IDLE, accept of halt: next cycle wb_valid=1, wb_reg_write=0, halted=1; enter HALT.
//  IDLE, accept of lw/sw with ex_alu_result[31:ADDR_W] != 0 (includes negative addresses):
//    no request is issued; mem_error=1; wb_valid stays 0; enter ERR.
//  IDLE, accept of lw/sw with a legal address:
//    latch mem_addr = ex_alu_result[ADDR_W-1:0], mem_wdata = ex_regb_value,
//    mem_we = (opcode==sw), dest, and reg_write.
//    Next cycle: mem_req=1; enter REQ; counter=0.
//  REQ: mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack cycle.
//    mem_ack=1: mem_req drops the next cycle, wb_valid=1 the next cycle, return to IDLE.
//      lw: wb_data = mem_rdata captured in the ack cycle; wb_reg_write=1.
//      sw: wb_data = stored value; wb_reg_write=0.
//    Minimum load/store latency is 2 cycles (accept -> req, ack in the first req cycle -> wb).
//    mem_ack=0: counter increments. When counter reaches TIMEOUT-1 without ack:
//      mem_req=0, mem_error=1, enter ERR.
//  mem_ack while not in REQ is ignored.
//  HALT and ERR are terminal until reset: ex_ready=0, mem_req=0, wb_valid=0.
//  wb_* fields hold their last value while wb_valid=0; only wb_valid qualifies them.
//  There is no combinational path from ex_* to any output except through ex_ready (state only).
// TESTING
//  1. add: ex_valid, op=0, alu=0x0000_0005, dest=3, rw=1
//     -> next cycle wb_valid=1, wb_data=5, wb_dest_reg=3, wb_reg_write=1; back-to-back adds retire every cycle.
//  2. sw: alu=0x0A, regb=0xDEAD_BEEF; ack in the 3rd REQ cycle
//     -> mem_req high 3 cycles, mem_we=1, mem_addr=0x0A, ex_ready=0 throughout;
//        wb_valid=1 with wb_reg_write=0 the cycle after ack.
//  3. lw: alu=0x0A, ack in the first REQ cycle with rdata=0x1234
//     -> wb_valid=1 with wb_data=0x1234, wb_reg_write=1, exactly 2 cycles after accept.
//  4. lw: alu=0x40 (ADDR_W=6) -> mem_req never rises, mem_error=1, ex_ready stays 0 until reset.
//  5. lw with no ack -> mem_req drops after 16 cycles, mem_error=1;
//     then reset -> all outputs 0 and the next add retires normally.
//  6. halt, then add offered -> halted=1 and one wb_valid pulse;
//     the add is never accepted; reset asserted mid-REQ returns to IDLE with mem_req=0.

Source files
------------

// File: rtl/lc2k_mem_stage.sv
// LC2K memory stage: holds the EX/MEM instruction, runs a req/ack handshake to data memory, emits one MEM/WB result.
// Latency: 1 cycle for non-memory ops, minimum 2 cycles for lw/sw (accept -> req, ack -> wb).
// Backpressure: ex_ready is high only in IDLE; execute is stalled for the whole REQ phase and forever after halt/error.
//
// Ports: clk/reset (sync, active-high); ex_* instruction from execute with ex_valid/ex_ready;
// mem_* request/ack interface to data memory; wb_* registered MEM/WB result qualified by wb_valid;
// halted / mem_error sticky status flags.
module lc2k_mem_stage #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_opcode,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_regb_value,
  input  logic [2:0]        ex_dest_reg,
  input  logic              ex_reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [2:0]        wb_opcode,
  output logic [31:0]       wb_data,
  output logic [2:0]        wb_dest_reg,
  output logic              wb_reg_write,
  output logic              halted,
  output logic              mem_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [2:0]          pend_dest_q, pend_dest_d;
  logic                wb_valid_q, wb_valid_d;
  logic [2:0]          wb_opcode_q, wb_opcode_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [2:0]          wb_dest_q, wb_dest_d;
  logic                wb_rw_q, wb_rw_d;
  logic                halted_q, halted_d;
  logic                mem_error_q, mem_error_d;

  logic                is_mem_op;
  logic                addr_bad;

  assign is_mem_op = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
  // Any upper bit set means out of range; this also catches negative addresses.
  assign addr_bad  = (ex_alu_result[31:ADDR_W] != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_dest_d = pend_dest_q;
    wb_valid_d  = 1'b0;
    wb_opcode_d = wb_opcode_q;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_rw_d     = wb_rw_q;
    halted_d    = halted_q;
    mem_error_d = mem_error_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (is_mem_op) begin
            if (addr_bad) begin
              mem_error_d = 1'b1;
              state_d     = S_ERR;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = (ex_opcode == OP_SW);
              mem_addr_d  = ex_alu_result[ADDR_W-1:0];
              mem_wdata_d = ex_regb_value;
              pend_dest_d = ex_dest_reg;
              cnt_d       = '0;
              state_d     = S_REQ;
            end
          end else begin
            wb_valid_d  = 1'b1;
            wb_opcode_d = ex_opcode;
            wb_data_d   = ex_alu_result;
            wb_dest_d   = ex_dest_reg;
            if (ex_opcode == OP_HALT) begin
              wb_rw_d  = 1'b0;
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              wb_rw_d  = ex_reg_write;
            end
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          wb_valid_d  = 1'b1;
          wb_opcode_d = mem_we_q ? OP_SW : OP_LW;
          // A store retires its data for visibility but never writes the register file.
          wb_data_d   = mem_we_q ? mem_wdata_q : mem_rdata;
          wb_rw_d     = ~mem_we_q;
          wb_dest_d   = pend_dest_q;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          mem_error_d = 1'b1;
          state_d     = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: ; // HALT and ERR hold everything until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pend_dest_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_opcode_q <= '0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_rw_q     <= 1'b0;
      halted_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_dest_q <= pend_dest_d;
      wb_valid_q  <= wb_valid_d;
      wb_opcode_q <= wb_opcode_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_rw_q     <= wb_rw_d;
      halted_q    <= halted_d;
      mem_error_q <= mem_error_d;
    end
  end

  // ex_ready depends on state (and reset) only, never on ex_* inputs.
  assign ex_ready     = (state_q == S_IDLE) && !reset;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_opcode    = wb_opcode_q;
  assign wb_data      = wb_data_q;
  assign wb_dest_reg  = wb_dest_q;
  assign wb_reg_write = wb_rw_q;
  assign halted       = halted_q;
  assign mem_error    = mem_error_q;

endmodule

// File: tb/tb_lc2k_mem_stage.sv
// Directed self-checking bench for lc2k_mem_stage.
// Inputs are driven 1 time unit after each rising edge and outputs sampled at the same point.
// Memory ack is driven by hand to control REQ length.
module tb_lc2k_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_opcode;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_regb_value;
  logic [2:0]  ex_dest_reg;
  logic        ex_reg_write;
  logic        mem_req;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [2:0]  wb_opcode;
  logic [31:0] wb_data;
  logic [2:0]  wb_dest_reg;
  logic        wb_reg_write;
  logic        halted;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  lc2k_mem_stage #(.ADDR_W(6), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_alu_result(ex_alu_result), .ex_regb_value(ex_regb_value),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_data(wb_data),
    .wb_dest_reg(wb_dest_reg), .wb_reg_write(wb_reg_write),
    .halted(halted), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] alu,
                       input logic [31:0] regb, input logic [2:0] dest, input logic rw);
    ex_valid      = v;
    ex_opcode     = op;
    ex_alu_result = alu;
    ex_regb_value = regb;
    ex_dest_reg   = dest;
    ex_reg_write  = rw;
  endtask

  task automatic idle_in();
    drive(1'b0, 3'd7, 32'h0, 32'h0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    mem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    idle_in();
    step();
    step();
    // Reset state, sampled while reset is still asserted.
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd0);
    chk("rst_mem_req",  {31'b0, mem_req},  32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data",  wb_data,           32'd0);
    chk("rst_halted",   {31'b0, halted},   32'd0);
    chk("rst_mem_err",  {31'b0, mem_error},32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ex_ready", {31'b0, ex_ready}, 32'd1);

    // 1. add, then back-to-back second add.
    drive(1'b1, 3'd0, 32'h5, 32'h0, 3'd3, 1'b1);
    step();
    chk("add1_vld",  {31'b0, wb_valid},     32'd1);
    chk("add1_data", wb_data,               32'd5);
    chk("add1_dest", {29'b0, wb_dest_reg},  32'd3);
    chk("add1_rw",   {31'b0, wb_reg_write}, 32'd1);
    chk("add1_rdy",  {31'b0, ex_ready},     32'd1);
    drive(1'b1, 3'd1, 32'h7, 32'h0, 3'd2, 1'b0);
    step();
    chk("add2_vld",  {31'b0, wb_valid},     32'd1);
    chk("add2_data", wb_data,               32'd7);
    chk("add2_op",   {29'b0, wb_opcode},    32'd1);
    chk("add2_rw",   {31'b0, wb_reg_write}, 32'd0);
    idle_in();
    mem_ack = 1'b1; // stray ack in IDLE must be ignored
    step();
    mem_ack = 1'b0;
    chk("idle_vld",  {31'b0, wb_valid}, 32'd0);
    chk("hold_data", wb_data,           32'd7);

    // 2. sw, ack in 3rd REQ cycle.
    drive(1'b1, 3'd3, 32'h0A, 32'hDEADBEEF, 3'd4, 1'b0);
    step();
    idle_in();
    chk("sw_req1",   {31'b0, mem_req},  32'd1);
    chk("sw_we",     {31'b0, mem_we},   32'd1);
    chk("sw_addr",   {26'b0, mem_addr}, 32'h0A);
    chk("sw_wdata",  mem_wdata,         32'hDEADBEEF);
    chk("sw_rdy1",   {31'b0, ex_ready}, 32'd0);
    step();
    chk("sw_req2",   {31'b0, mem_req},  32'd1);
    chk("sw_rdy2",   {31'b0, ex_ready}, 32'd0);
    step();
    chk("sw_req3",   {31'b0, mem_req},  32'd1);
    chk("sw_addr3",  {26'b0, mem_addr}, 32'h0A);
    chk("sw_nowb",   {31'b0, wb_valid}, 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sw_reqdrop", {31'b0, mem_req},      32'd0);
    chk("sw_wb_vld",  {31'b0, wb_valid},     32'd1);
    chk("sw_wb_rw",   {31'b0, wb_reg_write}, 32'd0);
    chk("sw_wb_data", wb_data,               32'hDEADBEEF);
    chk("sw_wb_op",   {29'b0, wb_opcode},    32'd3);
    chk("sw_rdy",     {31'b0, ex_ready},     32'd1);

    // 3. lw, ack in first REQ cycle -> wb 2 cycles after accept.
    drive(1'b1, 3'd2, 32'h0A, 32'h0, 3'd5, 1'b1);
    step();
    idle_in();
    chk("lw_req",    {31'b0, mem_req},  32'd1);
    chk("lw_we",     {31'b0, mem_we},   32'd0);
    chk("lw_nowb",   {31'b0, wb_valid}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("lw_wb_vld",  {31'b0, wb_valid},     32'd1);
    chk("lw_wb_data", wb_data,               32'h1234);
    chk("lw_wb_rw",   {31'b0, wb_reg_write}, 32'd1);
    chk("lw_wb_dest", {29'b0, wb_dest_reg},  32'd5);
    step();
    chk("lw_pulse",   {31'b0, wb_valid},     32'd0);

    // 4. lw with out-of-range address.
    drive(1'b1, 3'd2, 32'h40, 32'h0, 3'd1, 1'b1);
    step();
    idle_in();
    chk("bad_err",  {31'b0, mem_error}, 32'd1);
    chk("bad_req",  {31'b0, mem_req},   32'd0);
    chk("bad_wb",   {31'b0, wb_valid},  32'd0);
    drive(1'b1, 3'd0, 32'h1, 32'h0, 3'd1, 1'b1);
    step();
    step();
    chk("bad_req2", {31'b0, mem_req},  32'd0);
    chk("bad_rdy",  {31'b0, ex_ready}, 32'd0);
    chk("bad_wb2",  {31'b0, wb_valid}, 32'd0);
    do_reset();
    #1;
    chk("bad_clr",  {31'b0, mem_error}, 32'd0);

    // Negative address on sw also errors.
    drive(1'b1, 3'd3, 32'hFFFF_FFFF, 32'h55, 3'd1, 1'b0);
    step();
    idle_in();
    chk("neg_err",  {31'b0, mem_error}, 32'd1);
    chk("neg_req",  {31'b0, mem_req},   32'd0);
    do_reset();

    // 5. lw with no ack -> timeout after 16 REQ cycles.
    drive(1'b1, 3'd2, 32'h03, 32'h0, 3'd2, 1'b1);
    step();
    idle_in();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", n,                   32'd16);
    chk("to_err",    {31'b0, mem_error},  32'd1);
    chk("to_rdy",    {31'b0, ex_ready},   32'd0);
    chk("to_wb",     {31'b0, wb_valid},   32'd0);
    reset = 1'b1;
    step();
    chk("to_rst_err", {31'b0, mem_error}, 32'd0);
    chk("to_rst_req", {31'b0, mem_req},   32'd0);
    chk("to_rst_wbd", wb_data,            32'd0);
    chk("to_rst_rdy", {31'b0, ex_ready},  32'd0);
    reset = 1'b0;
    drive(1'b1, 3'd0, 32'h9, 32'h0, 3'd6, 1'b1);
    step();
    idle_in();
    chk("to_add_vld",  {31'b0, wb_valid}, 32'd1);
    chk("to_add_data", wb_data,           32'd9);

    // 6. halt, then add offered.
    drive(1'b1, 3'd6, 32'h22, 32'h0, 3'd7, 1'b1);
    step();
    chk("halt_vld",  {31'b0, wb_valid},     32'd1);
    chk("halt_flag", {31'b0, halted},       32'd1);
    chk("halt_rw",   {31'b0, wb_reg_write}, 32'd0);
    chk("halt_rdy",  {31'b0, ex_ready},     32'd0);
    drive(1'b1, 3'd0, 32'h77, 32'h0, 3'd1, 1'b1);
    step();
    chk("halt_vld2", {31'b0, wb_valid},  32'd0);
    step();
    chk("halt_vld3", {31'b0, wb_valid},  32'd0);
    chk("halt_op",   {29'b0, wb_opcode}, 32'd6);
    chk("halt_hold", {31'b0, halted},    32'd1);
    do_reset();

    // Reset mid-REQ abandons the access.
    drive(1'b1, 3'd2, 32'h11, 32'h0, 3'd1, 1'b1);
    step();
    idle_in();
    chk("mid_req",   {31'b0, mem_req},  32'd1);
    reset = 1'b1;
    step();
    chk("mid_req0",  {31'b0, mem_req},  32'd0);
    chk("mid_rdy0",  {31'b0, ex_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rdy1",  {31'b0, ex_ready}, 32'd1);
    step();
    chk("mid_idle",  {31'b0, mem_req},  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
